// File: rtl/decode_in_ctrl_pkg.sv
// Shared types and constants for the LC-3 decode input sequencer.
// Used by decode_in_ctrl and decode_in_ctrl_fifo.
package decode_in_ctrl_pkg;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] npc;
  } decode_in_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } decode_in_ctrl_state_e;

  localparam logic [15:0] DECODE_IN_PC_RESET_DEFAULT = 16'h3000;

endpackage

// File: rtl/decode_in_ctrl_fifo.sv
// Small circular FIFO of instruction/NPC pairs feeding the decode output stage.
// Pointers wrap modulo DEPTH (a power of two); clear empties the FIFO synchronously.
module decode_in_ctrl_fifo
  import decode_in_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  decode_in_entry_t mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/decode_in_ctrl.sv
// Decode-stage input sequencer: buffers fetched pairs and issues one per cycle to decode.
// Optional macro DECODE_IN_CTRL_BYPASS_EN lets a pair skip an empty FIFO for 1-edge latency.
module decode_in_ctrl
  import decode_in_ctrl_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] PC_RESET = DECODE_IN_PC_RESET_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [15:0]                fetch_instr,
  input  logic [15:0]                fetch_npc,
  output logic                       fetch_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       enable_decode,
  output logic [15:0]                dout,
  output logic [15:0]                npc_in,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_HOLD  = HOLD;

  logic [1:0]       state;
  decode_in_entry_t head;
  logic [31:0]      head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             issue_slot;

  assign fetch_ready = !fifo_full && !flush;
  assign push        = fetch_valid && fetch_ready;
  assign issue_slot  = !stall && !flush;
  assign pop         = issue_slot && !fifo_empty;
  assign head        = head_bits;

`ifdef DECODE_IN_CTRL_BYPASS_EN
  // Only an empty FIFO may be bypassed, so program order is never violated.
  assign bypass = issue_slot && fifo_empty && push;
`else
  assign bypass = 1'b0;
`endif

  decode_in_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push && !bypass),
    .pop   (pop),
    .clear (flush),
    .wdata ({fetch_instr, fetch_npc}),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign enable_decode = (state != S_IDLE);

  // Flush beats stall beats issue; HOLD with stall released falls through to the issue path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      dout   <= 16'h0000;
      npc_in <= PC_RESET;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (stall) begin
      if (state == S_ISSUE) state <= S_HOLD;
    end else if (pop) begin
      state  <= S_ISSUE;
      dout   <= head.instr;
      npc_in <= head.npc;
    end else if (bypass) begin
      state  <= S_ISSUE;
      dout   <= fetch_instr;
      npc_in <= fetch_npc;
    end else begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_decode_in_ctrl.sv
// Scoreboard bench for decode_in_ctrl: stimulus queues expected pairs, a monitor checks each issue.
// Latency expectations follow DECODE_IN_CTRL_BYPASS_EN when it is defined.
module tb_decode_in_ctrl;
  import decode_in_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_instr = 16'h0000;
  logic [15:0] fetch_npc = 16'h0000;
  logic        fetch_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [2:0]  occupancy;

  int tests = 0;
  int fails = 0;
  int issue_count = 0;
  int lat;

  decode_in_entry_t sb[$];

  logic prev_en = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_flush = 1'b0;

  decode_in_ctrl #(.DEPTH(4), .PC_RESET(16'h3000)) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .fetch_instr   (fetch_instr),
    .fetch_npc     (fetch_npc),
    .fetch_ready   (fetch_ready),
    .stall         (stall),
    .flush         (flush),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .occupancy     (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then wait for the next rising edge plus 1 time unit.
  task automatic apply_stimulus(input logic v, input logic [15:0] i, input logic [15:0] n,
                                input logic st, input logic fl, input logic accept);
    fetch_valid = v;
    fetch_instr = i;
    fetch_npc   = n;
    stall       = st;
    flush       = fl;
    if (v && accept) sb.push_back({i, n});
    #1;
    if (v) check_output("fetch_ready", 16'(fetch_ready), 16'(accept));
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycle(input logic st);
    apply_stimulus(1'b0, 16'h0000, 16'h0000, st, 1'b0, 1'b0);
  endtask

  // A freshly presented instruction: enable rose, or the previous one was consumed.
  always @(negedge clock) begin
    if (reset) begin
      prev_en = 1'b0;
    end else begin
      if (enable_decode && (!prev_en || (!prev_stall && !prev_flush))) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_issue: got dout %h, expected no issue at %0t", dout, $time);
        end else begin
          decode_in_entry_t e;
          e = sb.pop_front();
          check_output("issue_instr", dout, e.instr);
          check_output("issue_npc", npc_in, e.npc);
          issue_count++;
        end
      end
      prev_en    = enable_decode;
      prev_stall = stall;
      prev_flush = flush;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
`ifdef DECODE_IN_CTRL_BYPASS_EN
    lat = 1;
`else
    lat = 2;
`endif
    // Reset asserted between edges must act immediately.
    #2 reset = 1'b1;
    #1;
    check_output("rst_enable", 16'(enable_decode), 16'h0);
    check_output("rst_dout", dout, 16'h0000);
    check_output("rst_npc", npc_in, 16'h3000);
    check_output("rst_occ", 16'(occupancy), 16'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_output("rst_ready", 16'(fetch_ready), 16'h1);
    @(posedge clock);
    #1;

    // Single issue
    apply_stimulus(1'b1, 16'h1234, 16'h3001, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      check_output("single_enable", 16'(enable_decode), 16'(k == lat));
      if (k == lat) begin
        check_output("single_dout", dout, 16'h1234);
        check_output("single_npc", npc_in, 16'h3001);
      end
      if (k < 3) idle_cycle(1'b0);
    end

    // Full: five offers under stall, only four fit
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b1, 16'hA000 + 16'(i), 16'h3010 + 16'(i), 1'b1, 1'b0, i < 4);
    check_output("full_occ", 16'(occupancy), 16'h4);
    check_output("full_ready", 16'(fetch_ready), 16'h0);
    for (int k = 0; k < 4; k++) begin
      idle_cycle(1'b0);
      check_output("drain_enable", 16'(enable_decode), 16'h1);
      check_output("drain_occ", 16'(occupancy), 16'(3 - k));
    end
    idle_cycle(1'b0);
    check_output("drain_done", 16'(enable_decode), 16'h0);

    // Stall hold
    apply_stimulus(1'b1, 16'h5020, 16'h3100, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 16'h5021, 16'h3101, 1'b1, 1'b0, 1'b1);
    idle_cycle(1'b0);
    check_output("hold_start", dout, 16'h5020);
    for (int k = 0; k < 3; k++) begin
      idle_cycle(1'b1);
      check_output("hold_enable", 16'(enable_decode), 16'h1);
      check_output("hold_dout", dout, 16'h5020);
      check_output("hold_npc", npc_in, 16'h3100);
    end
    idle_cycle(1'b0);
    check_output("hold_next", dout, 16'h5021);
    check_output("hold_next_en", 16'(enable_decode), 16'h1);
    idle_cycle(1'b0);
    check_output("hold_idle", 16'(enable_decode), 16'h0);

    // Flush with a same-cycle offer and stall
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, 16'hD000 + 16'(i), 16'h3200 + 16'(i), 1'b1, 1'b0, 1'b1);
    idle_cycle(1'b0);
    check_output("preflush_en", 16'(enable_decode), 16'h1);
    check_output("preflush_occ", 16'(occupancy), 16'h3);
    apply_stimulus(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    sb.delete();
    check_output("flush_occ", 16'(occupancy), 16'h0);
    check_output("flush_en", 16'(enable_decode), 16'h0);
    for (int k = 0; k < 3; k++) begin
      idle_cycle(1'b0);
      check_output("postflush_en", 16'(enable_decode), 16'h0);
    end

    // Wrap-around: 20 back-to-back pushes
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 16'hC000 + 16'(i), 16'h4000 + 16'(i), 1'b0, 1'b0, 1'b1);
      check_output("wrap_occ_le2", 16'(occupancy <= 3'd2), 16'h1);
    end
    for (int k = 0; k < 3; k++) idle_cycle(1'b0);

    check_output("issue_total", 16'(issue_count), 16'd28);
    check_output("sb_empty", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
